// File: rtl/i2c_codec_cfg_seq_if.sv
// Byte-level I2C engine handshake shared by the configuration sequencer
// (master) and the transaction engine (slave).
interface i2c_codec_cfg_seq_if;
    logic        i2c_tick;
    logic        i2c_req;
    logic [23:0] i2c_wdata;
    logic        i2c_done;
    logic        i2c_ack;

    modport master (
        output i2c_tick, i2c_req, i2c_wdata,
        input  i2c_done, i2c_ack
    );

    modport slave (
        input  i2c_tick, i2c_req, i2c_wdata,
        output i2c_done, i2c_ack
    );
endinterface

// File: rtl/i2c_codec_cfg_seq.sv
// Table-driven codec register sequencer: walks {op, reg, data} entries and issues
// one I2C write per entry with NACK retry, timed delays and sticky status.
module i2c_codec_cfg_seq #(
    parameter int         N_ENTRIES      = 64,
    parameter logic [7:0] DEV_ADDR       = 8'h20,
    parameter int         CLK_FREQ_HZ    = 12000000,
    parameter int         I2C_FREQ_HZ    = 100000,
    parameter int         DELAY_UNIT_CYC = 12000,
    parameter int         MAX_RETRY      = 3,
    parameter int         PWRUP_UNITS    = 10,
    parameter int         AUTO_START     = 1,
    localparam int        IDX_W          = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic                     clk_12M,
    input  logic                     rstn,
    input  logic                     cfg_start,
    output logic [IDX_W-1:0]         tbl_addr,
    input  logic [17:0]              tbl_data,
    i2c_codec_cfg_seq_if.master      bus,
    output logic                     busy,
    output logic                     reg_conf_done,
    output logic                     cfg_err,
    output logic [IDX_W-1:0]         err_index
);

    localparam int TICK_DIV = CLK_FREQ_HZ / (2 * I2C_FREQ_HZ);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CYC_W    = (DELAY_UNIT_CYC > 1) ? $clog2(DELAY_UNIT_CYC) : 1;
    localparam int RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CYC_W-1:0]   CYC_LAST  = CYC_W'(DELAY_UNIT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_ENTRIES - 1);

    typedef enum logic [3:0] {
        S_PWRUP, S_IDLE, S_FETCH, S_DECODE, S_XFER, S_GAP, S_WAIT, S_NEXT, S_DONE
    } state_t;

    state_t             state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [15:0]        units_left;
    logic [IDX_W-1:0]   index;
    logic [RETRY_W-1:0] retry;
    logic [2:0]         gap_cnt;

    // A delay of zero units finishes at once; otherwise on the last cycle of the last unit.
    logic unit_wrap;
    logic dly_over;
    assign unit_wrap = (cyc_cnt == CYC_LAST);
    assign dly_over  = (units_left == 16'd0) || (unit_wrap && units_left == 16'd1);
    assign tbl_addr  = index;

    // NOTE: every flop below is updated with <= so all state advances on the same edge.
    always_ff @(posedge clk_12M or negedge rstn) begin
        if (!rstn) begin
            tick_cnt     <= '0;
            bus.i2c_tick <= 1'b0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt     <= '0;
            bus.i2c_tick <= 1'b1;
        end else begin
            tick_cnt     <= tick_cnt + 1'b1;
            bus.i2c_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk_12M or negedge rstn) begin
        if (!rstn) begin
            state         <= S_PWRUP;
            cyc_cnt       <= '0;
            units_left    <= 16'(PWRUP_UNITS);
            index         <= '0;
            retry         <= '0;
            gap_cnt       <= '0;
            bus.i2c_req   <= 1'b0;
            bus.i2c_wdata <= '0;
            busy          <= 1'b0;
            reg_conf_done <= 1'b0;
            cfg_err       <= 1'b0;
            err_index     <= '0;
        end else begin
            case (state)
                S_PWRUP: begin
                    if (dly_over) begin
                        state <= (AUTO_START != 0) ? S_FETCH : S_IDLE;
                        busy  <= (AUTO_START != 0);
                    end else begin
                        cyc_cnt <= unit_wrap ? '0 : cyc_cnt + 1'b1;
                        if (unit_wrap) units_left <= units_left - 16'd1;
                    end
                end
                S_IDLE: begin
                    if (cfg_start) begin
                        reg_conf_done <= 1'b0;
                        cfg_err       <= 1'b0;
                        err_index     <= '0;
                        index         <= '0;
                        retry         <= '0;
                        busy          <= 1'b1;
                        state         <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    case (tbl_data[17:16])
                        2'd1: begin
                            units_left <= tbl_data[15:0];
                            cyc_cnt    <= '0;
                            state      <= S_WAIT;
                        end
                        2'd2: state <= S_DONE;
                        default: begin
                            bus.i2c_wdata <= {DEV_ADDR, tbl_data[15:0]};
                            bus.i2c_req   <= 1'b1;
                            state         <= S_XFER;
                        end
                    endcase
                end
                S_XFER: begin
                    if (bus.i2c_done) begin
                        bus.i2c_req <= 1'b0;
                        if (bus.i2c_ack) begin
                            state <= S_NEXT;
                        end else if (retry != RETRY_MAX) begin
                            retry   <= retry + 1'b1;
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            err_index <= index;
                            cfg_err   <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                // The first tick only aligns to the tick grid; four full periods follow.
                S_GAP: begin
                    if (bus.i2c_tick) begin
                        if (gap_cnt == 3'd4) begin
                            bus.i2c_req <= 1'b1;
                            state       <= S_XFER;
                        end else begin
                            gap_cnt <= gap_cnt + 3'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (dly_over) begin
                        state <= S_NEXT;
                    end else begin
                        cyc_cnt <= unit_wrap ? '0 : cyc_cnt + 1'b1;
                        if (unit_wrap) units_left <= units_left - 16'd1;
                    end
                end
                S_NEXT: begin
                    retry <= '0;
                    if (index == IDX_LAST) begin
                        state <= S_DONE;
                    end else begin
                        index <= index + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    reg_conf_done <= 1'b1;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_codec_cfg_seq.md
Name: i2c_codec_cfg_seq

Overview:
- Parametrised, table-driven I2C register-configuration sequencer for audio codecs (ES7243E ADC, DAC and similar parts).
- Walks an external configuration table of writes, timed delays and an end marker, issuing one I2C write per entry to a byte-level I2C transaction engine.
- Adds NACK retry, programmable delays, a power-up wait, re-triggering and error reporting. Runs entirely in the system clock domain; the engine is clocked by the generated tick.

Parameters:
- N_ENTRIES, 64, table depth; maximum entries walked.
- DEV_ADDR, 8'h20, 8-bit device write address placed in every transaction.
- CLK_FREQ_HZ, 12000000, input clock frequency.
- I2C_FREQ_HZ, 100000, SCL rate; the tick is generated at 2×I2C_FREQ_HZ.
- DELAY_UNIT_CYC, 12000, clock cycles per delay unit (1 ms at 12 MHz).
- MAX_RETRY, 3, retries per entry after the first NACK.
- PWRUP_UNITS, 10, delay units waited after reset before the first entry.
- AUTO_START, 1, 1 = start the sequence automatically after reset and power-up wait.

Ports:
- clk_12M  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle pulse; restarts the sequence from entry 0.
- tbl_addr  out  clog2(N_ENTRIES)  table read address.
- tbl_data  in  18  entry {op[1:0], reg_addr[7:0], reg_data[7:0]}; valid one cycle after tbl_addr changes.
- i2c_tick  out  1  one-cycle enable at 2×I2C_FREQ_HZ for the engine.
- i2c_req  out  1  transaction request, level.
- i2c_wdata  out  24  {DEV_ADDR, reg_addr, reg_data}.
- i2c_done  in  1  one-cycle pulse, transaction finished.
- i2c_ack  in  1  sampled with i2c_done; 1 = all three bytes ACKed.
- busy  out  1  sequence in progress.
- reg_conf_done  out  1  table completed without error; sticky until restart.
- cfg_err  out  1  entry failed after all retries; sticky until restart.
- err_index  out  clog2(N_ENTRIES)  index of the failing entry.

Behaviour:
- Reset (asynchronous, rstn=0): all outputs 0, state PWRUP, counters cleared, i2c_tick counter cleared.
- Tick generator:
  - Divider counts 0 to CLK_FREQ_HZ/(2·I2C_FREQ_HZ)−1.
  - i2c_tick=1 for one cycle at terminal count; free-running whenever rstn=1.
  - Defaults give one tick every 60 cycles.
- Entry op codes:
  - 0 = WRITE.
  - 1 = DELAY, {reg_addr, reg_data} units; 0 means no wait.
  - 2 = END.
  - 3 = reserved, treated as WRITE.
- States:
  - PWRUP: wait PWRUP_UNITS×DELAY_UNIT_CYC cycles, then go to FETCH if AUTO_START=1, else IDLE.
  - IDLE: busy=0. On cfg_start: clear reg_conf_done, cfg_err, index and retry count; go to FETCH.
  - FETCH: drive tbl_addr=index; wait 1 cycle; go to DECODE. busy=1 in every state other than IDLE and PWRUP.
  - DECODE:
    - WRITE: latch i2c_wdata, assert i2c_req, go to XFER.
    - DELAY: load the counter, go to WAIT.
    - END: go to DONE.
  - XFER: hold i2c_req and i2c_wdata stable until i2c_done. On i2c_done, deassert i2c_req the same edge.
    - i2c_ack=1: go to NEXT.
    - i2c_ack=0 and retry<MAX_RETRY: increment retry, go to GAP.
    - i2c_ack=0 and retry=MAX_RETRY: latch err_index=index, set cfg_err, go to IDLE.
  - GAP: wait 4 i2c_ticks with i2c_req=0, then re-issue the same entry (back to XFER, req=1).
  - WAIT: count down delay units; go to NEXT at zero.
  - NEXT: clear retry. If index=N_ENTRIES−1, go to DONE; else index+1, go to FETCH.
  - DONE: set reg_conf_done, go to IDLE.
- Simultaneous events:
  - cfg_start while busy: ignored; software must wait for busy=0.
  - cfg_start in IDLE on the same cycle reg_conf_done would set: not possible, because DONE precedes IDLE.
- Table end without an END entry: table completes after entry N_ENTRIES−1.
- Index width rule: index is clog2(N_ENTRIES) bits and never wraps, because the NEXT compare precedes the increment.
- Reset mid-transfer: i2c_req drops immediately; the engine is reset by the same rstn.
- i2c_done outside XFER: ignored.

Test Plan:
- Table {W 01/3A, W 00/80, END}, engine ACKs every request after 10 cycles -> exactly 2 requests:
  - i2c_wdata=24'h20013A, then 24'h200080.
  - reg_conf_done=1 and busy=0 after END.
  - First request issued 120000 cycles after reset release (PWRUP_UNITS=10).
- Entry 1 NACKed twice then ACKed -> 3 requests for entry 1, each separated by ≥240 cycles of i2c_req=0; cfg_err=0; reg_conf_done=1.
- Entry 2 always NACKed -> 4 requests for entry 2; then cfg_err=1, err_index=2, reg_conf_done=0, busy=0; no request for entry 3.
- Table {W, DELAY 0x0005, W, END} -> gap between the first i2c_done and the second i2c_req ≥ 60000 cycles and < 60010.
- cfg_start pulse after completion -> reg_conf_done clears within 1 cycle and the sequence replays from entry 0. cfg_start pulse while busy -> no effect.
- rstn low during XFER -> i2c_req=0 and all outputs 0 asynchronously. After release, PWRUP wait, then the sequence restarts at entry 0.
- Tick check: i2c_tick period measures exactly 60 cycles with defaults.
